riscv_test_monitor: RTL and testbench
=====================================

Name: riscv_test_monitor

Overview:
Synthesizable end-of-test monitor for riscv-tests runs on the pipelined core. It watches the fetch PC and the gp register (x3), and detects arrival at the configurable pass/fail trap address. It latches a pass, fail or timeout verdict together with the failing test number and the elapsed cycle count. It replaces ad-hoc PC polling in per-test benches and can also be instantiated in FPGA builds to drive status LEDs.

Parameters:
XLEN, 32, datapath width of pc and gp
PASS_PC, 32'h00000044, trap address that ends a test
TIMEOUT, 6000, cycles in RUN before a timeout verdict; must be at least 1
CNT_W, 16, width of the cycle counter; 2^CNT_W must exceed TIMEOUT
HIT_COUNT, 1, consecutive valid cycles at PASS_PC needed to declare completion (filters flush/stall glitches); must be at least 1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a monitored run
pc  in  XLEN  fetch-stage PC (if_pc)
pc_valid  in  1  pc is meaningful this cycle (not a bubble/flush)
gp  in  XLEN  current value of register x3
done  out  1  verdict available (sticky)
pass  out  1  gp == 1 at completion
fail  out  1  gp != 1 at completion
timeout  out  1  TIMEOUT reached without completion
fail_test  out  XLEN-1  gp >> 1 at completion (failing test number); 0 otherwise
cycles  out  CNT_W  cycles spent in RUN; frozen in DONE

Behaviour:
- Reset (synchronous, active-high, on a clk edge):
  - state = IDLE; hit counter = 0.
  - done, pass, fail, timeout, fail_test and cycles all = 0.
  - rst has priority over every other input, including in mid-run.
- State IDLE:
  - Outputs hold their values.
  - start=1 -> RUN; cycles and hit counter cleared to 0; verdict outputs cleared to 0.
- State RUN, evaluated each cycle:
  - cycles increments by 1 each cycle.
  - hit = pc_valid && (pc == PASS_PC).
  - hit=1 -> hit counter += 1 (saturating at HIT_COUNT); hit=0 -> hit counter = 0.
  - Completion: hit=1 and (hit counter + 1) == HIT_COUNT. That edge does the following:
    - Samples the gp value present in that cycle.
    - pass = (gp == 1); fail = !pass; fail_test = fail ? gp[XLEN-1:1] : 0.
    - done = 1; state -> DONE.
  - Timeout: no completion and cycles == TIMEOUT-1 in the current cycle. That edge sets timeout=1, done=1, pass=0, fail=0, state -> DONE.
  - Completion and timeout in the same cycle: completion wins; timeout stays 0.
  - start while in RUN is ignored.
- State DONE:
  - All outputs are held (sticky); cycles is frozen.
  - start=1 -> behaves exactly as start from IDLE (clears the verdict, enters RUN).
- Latency:
  - The verdict becomes visible on the outputs the cycle after the qualifying sample (registered).
  - With HIT_COUNT=1, done rises one clk after the first valid cycle with pc == PASS_PC.
- Exactly one of pass, fail or timeout is 1 whenever done=1; all three are 0 whenever done=0.
- The monitor never reads or modifies core state; it is purely observational.

Test Plan:
- rst, then start. Drive pc ramping to 32'h44 with pc_valid=1 at cycle 200 and gp=1 -> next cycle done=1, pass=1, fail=0, timeout=0, fail_test=0, cycles=201.
- Same run with gp=32'h0000000B at the hit -> done=1, fail=1, fail_test=5, pass=0.
- HIT_COUNT=3. pc=32'h44 valid for 2 cycles, one bubble (pc_valid=0), then 3 consecutive valid cycles -> done only after the third consecutive cycle; the first two hits are ignored.
- Never reach PASS_PC with TIMEOUT=50 -> done=1, timeout=1 one clk after cycles reaches 49; pass=fail=0; cycles holds 50.
- Hit arrives exactly in cycle TIMEOUT-1 with gp=1 -> pass=1, timeout=0. Then pulse start in DONE -> all verdicts clear, cycles restarts from 0.
- Assert rst mid-RUN at cycle 30 -> next cycle state IDLE, all outputs 0. A later pc=32'h44 without start produces no verdict.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests runs: watches fetch PC and gp (x3)
// and latches a sticky pass/fail/timeout verdict with the elapsed cycles.
module riscv_test_monitor #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] PASS_PC   = 'h44,
  parameter int              TIMEOUT   = 6000,
  parameter int              CNT_W     = 16,
  parameter int              HIT_COUNT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  gp,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [XLEN-2:0]  fail_test,
  output logic [CNT_W-1:0] cycles
);

  localparam int HW = $clog2(HIT_COUNT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hit_q, hit_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-2:0]  fail_test_q, fail_test_d;

  logic hit;
  logic complete;
  logic gp_one;

  assign hit      = pc_valid && (pc == PASS_PC);
  assign complete = hit && ((int'(hit_q) + 1) == HIT_COUNT);
  assign gp_one   = (gp == XLEN'(1));

  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    cycles_d    = cycles_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_test_d = fail_test_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          hit_d       = '0;
          cycles_d    = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          timeout_d   = 1'b0;
          fail_test_d = '0;
        end
      end
      S_RUN: begin
        cycles_d = cycles_q + 1'b1;
        if (!hit) begin
          hit_d = '0;
        end else if (hit_q != HW'(HIT_COUNT)) begin
          hit_d = hit_q + 1'b1;
        end
        // completion takes precedence over a coincident timeout
        if (complete) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          pass_d      = gp_one;
          fail_d      = !gp_one;
          fail_test_d = gp_one ? '0 : gp[XLEN-1:1];
        end else if (cycles_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hit_q       <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_test_q <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_test_q <= fail_test_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign fail_test = fail_test_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: instance A (HIT_COUNT=1, TIMEOUT=300)
// and instance B (HIT_COUNT=3, TIMEOUT=50) share one stimulus stream.
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_valid = 1'b0;
  logic [31:0] gp = 32'h0;

  logic        a_done, a_pass, a_fail, a_timeout;
  logic [30:0] a_fail_test;
  logic [15:0] a_cycles;
  logic        b_done, b_pass, b_fail, b_timeout;
  logic [30:0] b_fail_test;
  logic [15:0] b_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .XLEN(32), .PASS_PC(32'h44), .TIMEOUT(300),
    .CNT_W(16), .HIT_COUNT(1)
  ) u_a (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .pc_valid(pc_valid), .gp(gp), .done(a_done),
    .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
    .fail_test(a_fail_test), .cycles(a_cycles)
  );

  riscv_test_monitor #(
    .XLEN(32), .PASS_PC(32'h44), .TIMEOUT(50),
    .CNT_W(16), .HIT_COUNT(3)
  ) u_b (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .pc_valid(pc_valid), .gp(gp), .done(b_done),
    .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
    .fail_test(b_fail_test), .cycles(b_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pc_valid = 1'b0;
    pc = 32'h0; gp = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_done, a_pass, a_fail, a_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_a_flags got %b want 0000",
               {a_done, a_pass, a_fail, a_timeout});
    end
    checks++;
    if (a_cycles !== 16'd0 || a_fail_test !== 31'd0) begin
      errors++;
      $display("FAIL reset_a_cnt got cyc=%0d ft=%0d want 0/0",
               a_cycles, a_fail_test);
    end
    checks++;
    if ({b_done, b_pass, b_fail, b_timeout} !== 4'b0000 ||
        b_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_b got %b cyc=%0d want 0000 cyc=0",
               {b_done, b_pass, b_fail, b_timeout}, b_cycles);
    end
  endtask

  task automatic run_to_hit(input logic [31:0] gp_val);
    do_reset();
    do_start();
    pc_valid = 1'b1;
    gp = 32'h0;
    for (int i = 0; i < 200; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      start = (i == 100);
      tick();
    end
    start = 1'b0;
    pc = 32'h44;
    gp = gp_val;
    tick();
    pc = 32'h48;
  endtask

  task automatic test_pass();
    run_to_hit(32'h1);
    checks++;
    if ({a_done, a_pass, a_fail, a_timeout} !== 4'b1100) begin
      errors++;
      $display("FAIL pass_flags got %b want 1100",
               {a_done, a_pass, a_fail, a_timeout});
    end
    checks++;
    if (a_cycles !== 16'd201 || a_fail_test !== 31'd0) begin
      errors++;
      $display("FAIL pass_cnt got cyc=%0d ft=%0d want 201/0",
               a_cycles, a_fail_test);
    end
    tick(); tick();
    checks++;
    if (a_cycles !== 16'd201 || a_done !== 1'b1 || a_pass !== 1'b1) begin
      errors++;
      $display("FAIL pass_sticky got cyc=%0d done=%b pass=%b want 201/1/1",
               a_cycles, a_done, a_pass);
    end
  endtask

  task automatic test_fail();
    run_to_hit(32'h0000000B);
    checks++;
    if ({a_done, a_pass, a_fail, a_timeout} !== 4'b1010) begin
      errors++;
      $display("FAIL fail_flags got %b want 1010",
               {a_done, a_pass, a_fail, a_timeout});
    end
    checks++;
    if (a_fail_test !== 31'd5 || a_cycles !== 16'd201) begin
      errors++;
      $display("FAIL fail_test got ft=%0d cyc=%0d want 5/201",
               a_fail_test, a_cycles);
    end
  endtask

  task automatic test_hit_filter();
    do_reset();
    do_start();
    gp = 32'h1;
    pc = 32'h44;
    pc_valid = 1'b1;
    tick(); tick();
    pc_valid = 1'b0;
    tick();
    checks++;
    if (b_done !== 1'b0) begin
      errors++;
      $display("FAIL filter_bubble got done=%b want 0", b_done);
    end
    pc_valid = 1'b1;
    tick(); tick();
    checks++;
    if (b_done !== 1'b0) begin
      errors++;
      $display("FAIL filter_two got done=%b want 0", b_done);
    end
    tick();
    pc_valid = 1'b0;
    checks++;
    if ({b_done, b_pass, b_fail, b_timeout} !== 4'b1100 ||
        b_cycles !== 16'd6) begin
      errors++;
      $display("FAIL filter_third got %b cyc=%0d want 1100 cyc=6",
               {b_done, b_pass, b_fail, b_timeout}, b_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    pc = 32'h100;
    pc_valid = 1'b1;
    for (int i = 0; i < 49; i++) tick();
    checks++;
    if (b_done !== 1'b0 || b_cycles !== 16'd49) begin
      errors++;
      $display("FAIL to_before got done=%b cyc=%0d want 0/49",
               b_done, b_cycles);
    end
    tick();
    checks++;
    if ({b_done, b_pass, b_fail, b_timeout} !== 4'b1001 ||
        b_cycles !== 16'd50) begin
      errors++;
      $display("FAIL to_verdict got %b cyc=%0d want 1001 cyc=50",
               {b_done, b_pass, b_fail, b_timeout}, b_cycles);
    end
    tick(); tick(); tick();
    checks++;
    if (b_cycles !== 16'd50 || b_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_frozen got cyc=%0d to=%b want 50/1",
               b_cycles, b_timeout);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start();
    pc = 32'h200;
    pc_valid = 1'b1;
    gp = 32'h1;
    for (int i = 0; i < 47; i++) tick();
    pc = 32'h44;
    tick(); tick(); tick();
    pc = 32'h48;
    checks++;
    if ({b_done, b_pass, b_fail, b_timeout} !== 4'b1100 ||
        b_cycles !== 16'd50) begin
      errors++;
      $display("FAIL edge_hit got %b cyc=%0d want 1100 cyc=50",
               {b_done, b_pass, b_fail, b_timeout}, b_cycles);
    end
    do_start();
    checks++;
    if ({b_done, b_pass, b_fail, b_timeout} !== 4'b0000 ||
        b_cycles !== 16'd0) begin
      errors++;
      $display("FAIL restart got %b cyc=%0d want 0000 cyc=0",
               {b_done, b_pass, b_fail, b_timeout}, b_cycles);
    end
    tick(); tick();
    checks++;
    if (b_cycles !== 16'd2 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_run got cyc=%0d done=%b want 2/0",
               b_cycles, b_done);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    do_start();
    pc = 32'h300;
    pc_valid = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (a_cycles !== 16'd30) begin
      errors++;
      $display("FAIL mid_pre got cyc=%0d want 30", a_cycles);
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({a_done, a_pass, a_fail, a_timeout} !== 4'b0000 ||
        a_cycles !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst got %b cyc=%0d want 0000 cyc=0",
               {a_done, a_pass, a_fail, a_timeout}, a_cycles);
    end
    pc = 32'h44;
    gp = 32'h1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (a_done !== 1'b0 || a_pass !== 1'b0 || a_cycles !== 16'd0 ||
        b_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hit got a_done=%b a_pass=%b cyc=%0d b_done=%b want 0/0/0/0",
               a_done, a_pass, a_cycles, b_done);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_hit_filter();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
